// File: rtl/aes_sram_pkg.sv
// Shared types and helpers for the byte-to-block adaptation between the SRAM port and the AES datapath.
package aes_sram_pkg;

    localparam int BLK_W = 128;

    typedef enum logic {P_FILL, P_FULL} packState_t;
    typedef enum logic {U_IDLE, U_SEND} unpackState_t;

    function automatic int idxWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/byte_serializer.sv
// Write side: latches one result block from the AES core and shifts it out one byte per SRAM write strobe.
module byte_serializer
    import aes_sram_pkg::*;
#(
    parameter int BYTES_PER_BLK = 16
)(
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       clr,
    input  logic                       w_en,
    input  logic [8*BYTES_PER_BLK-1:0] res_data,
    input  logic                       res_valid,
    output logic                       res_ready,
    output logic [7:0]                 w_data,
    output logic                       unf_err
);

    localparam int BW = 8 * BYTES_PER_BLK;
    localparam int CW = idxWidth(BYTES_PER_BLK);
    localparam logic [CW-1:0] LAST = CW'(BYTES_PER_BLK - 1);

    unpackState_t    r_state;
    logic [BW-1:0]   r_shift;
    logic [CW-1:0]   r_ucnt;
    logic            r_unfErr;

    // The outgoing byte always sits in the top lane, so w_data is a plain select gated by the state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= U_IDLE;
            r_shift  <= '0;
            r_ucnt   <= '0;
            r_unfErr <= 1'b0;
        end else if (clr) begin
            r_state  <= U_IDLE;
            r_shift  <= '0;
            r_ucnt   <= '0;
            r_unfErr <= 1'b0;
        end else begin
            case (r_state)
                U_IDLE: begin
                    if (w_en)
                        r_unfErr <= 1'b1;
                    if (res_valid) begin
                        r_shift <= res_data;
                        r_ucnt  <= '0;
                        r_state <= U_SEND;
                    end
                end
                U_SEND: begin
                    if (w_en) begin
                        r_shift <= {r_shift[BW-9:0], 8'h00};
                        if (r_ucnt == LAST) begin
                            r_ucnt  <= '0;
                            r_state <= U_IDLE;
                        end else begin
                            r_ucnt <= r_ucnt + CW'(1);
                        end
                    end
                end
                default: r_state <= U_IDLE;
            endcase
        end
    end

    assign w_data    = (r_state == U_SEND) ? r_shift[BW-1 -: 8] : 8'h00;
    assign res_ready = (r_state == U_IDLE);
    assign unf_err   = r_unfErr;

endmodule

// File: rtl/sram_block_packer.sv
// Packs SRAM read bytes into 128-bit blocks for the AES core and serialises result blocks back to SRAM.
module sram_block_packer
    import aes_sram_pkg::*;
#(
    parameter int BYTES_PER_BLK = 16,
    parameter int RD_LATENCY    = 1
)(
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       clr,
    input  logic                       r_en,
    input  logic [7:0]                 r_data,
    output logic [8*BYTES_PER_BLK-1:0] blk_data,
    output logic                       blk_valid,
    input  logic                       blk_ready,
    output logic                       rd_stall,
    input  logic                       w_en,
    output logic [7:0]                 w_data,
    input  logic [8*BYTES_PER_BLK-1:0] res_data,
    input  logic                       res_valid,
    output logic                       res_ready,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int BW = 8 * BYTES_PER_BLK;
    localparam int CW = idxWidth(BYTES_PER_BLK);
    localparam logic [CW-1:0] LAST = CW'(BYTES_PER_BLK - 1);

    logic [RD_LATENCY-1:0] r_rdPipe;
    logic                  w_rdValid;
    packState_t            r_packState;
    logic [CW-1:0]         r_pcnt;
    logic [BW-1:0]         r_blkData;
    logic                  r_ovfErr;

    // Mirrors the SRAM read latency so r_data is captured exactly when it is valid.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rdPipe <= '0;
        end else if (clr) begin
            r_rdPipe <= '0;
        end else begin
            r_rdPipe[0] <= r_en;
            for (int i = 1; i < RD_LATENCY; i++)
                r_rdPipe[i] <= r_rdPipe[i-1];
        end
    end

    assign w_rdValid = r_rdPipe[RD_LATENCY-1];

    // A byte arriving in the same cycle the pending block is accepted starts the next block at slot 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_packState <= P_FILL;
            r_pcnt      <= '0;
            r_blkData   <= '0;
            r_ovfErr    <= 1'b0;
        end else if (clr) begin
            r_packState <= P_FILL;
            r_pcnt      <= '0;
            r_blkData   <= '0;
            r_ovfErr    <= 1'b0;
        end else begin
            case (r_packState)
                P_FILL: begin
                    if (w_rdValid) begin
                        for (int s = 0; s < BYTES_PER_BLK; s++)
                            if (r_pcnt == CW'(s))
                                r_blkData[BW-1-8*s -: 8] <= r_data;
                        if (r_pcnt == LAST) begin
                            r_pcnt      <= '0;
                            r_packState <= P_FULL;
                        end else begin
                            r_pcnt <= r_pcnt + CW'(1);
                        end
                    end
                end
                P_FULL: begin
                    if (blk_ready) begin
                        r_packState <= P_FILL;
                        if (w_rdValid) begin
                            r_blkData[BW-1 -: 8] <= r_data;
                            r_pcnt               <= CW'(1);
                        end
                    end else if (w_rdValid) begin
                        r_ovfErr <= 1'b1;
                    end
                end
                default: r_packState <= P_FILL;
            endcase
        end
    end

    assign blk_data  = r_blkData;
    assign blk_valid = (r_packState == P_FULL);
    assign rd_stall  = (r_packState == P_FULL);
    assign ovf_err   = r_ovfErr;

    byte_serializer #(
        .BYTES_PER_BLK (BYTES_PER_BLK)
    ) uSerializer (
        .clk       (clk),
        .n_rst     (n_rst),
        .clr       (clr),
        .w_en      (w_en),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .w_data    (w_data),
        .unf_err   (unf_err)
    );

endmodule
